// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout FSM with per-denomination
// hopper inventory, restocking and shortfall fault reporting.
module change_dispenser #(
  parameter int INV_W    = 6,
  parameter int INIT_INV = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refund,
  input  logic [7:0]       credit,
  input  logic             coin_ack,
  input  logic             load,
  input  logic [1:0]       load_type,
  input  logic [INV_W-1:0] load_count,
  output logic             clear_credit,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [7:0]       shortfall,
  output logic [INV_W-1:0] inv_p,
  output logic [INV_W-1:0] inv_n,
  output logic [INV_W-1:0] inv_d,
  output logic [INV_W-1:0] inv_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [INV_W-1:0] INIT_V = INV_W'(INIT_INV);

  state_t           state_q;
  logic [7:0]       rem_q;
  logic [INV_W-1:0] stock_q [4];

  logic             sel_ok_d;
  logic [1:0]       sel_type_d;
  logic [INV_W:0]   ld_sum_d;
  logic [INV_W-1:0] ld_new_d;

  function automatic logic [7:0] coin_val(input logic [1:0] t);
    logic [7:0] v;
    unique case (t)
      2'd0:    v = 8'd1;
      2'd1:    v = 8'd5;
      2'd2:    v = 8'd10;
      default: v = 8'd25;
    endcase
    return v;
  endfunction

  // Largest denomination that fits the remainder and is in stock.
  always_comb begin
    sel_ok_d   = 1'b1;
    sel_type_d = 2'd0;
    if (rem_q >= 8'd25 && stock_q[3] != '0)
      sel_type_d = 2'd3;
    else if (rem_q >= 8'd10 && stock_q[2] != '0)
      sel_type_d = 2'd2;
    else if (rem_q >= 8'd5 && stock_q[1] != '0)
      sel_type_d = 2'd1;
    else if (rem_q != 8'd0 && stock_q[0] != '0)
      sel_type_d = 2'd0;
    else
      sel_ok_d = 1'b0;
  end

  // A carry out of the sum means the counter would exceed its maximum.
  always_comb begin
    ld_sum_d = {1'b0, stock_q[load_type]} + {1'b0, load_count};
    ld_new_d = ld_sum_d[INV_W] ? '1 : ld_sum_d[INV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rem_q        <= 8'd0;
      clear_credit <= 1'b0;
      coin_valid   <= 1'b0;
      coin_type    <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      shortfall    <= 8'd0;
      for (int i = 0; i < 4; i++)
        stock_q[i] <= INIT_V;
    end else begin
      clear_credit <= 1'b0;
      done         <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (load)
            stock_q[load_type] <= ld_new_d;
          if (refund) begin
            busy <= 1'b1;
            if (credit != 8'd0) begin
              rem_q        <= credit;
              clear_credit <= 1'b1;
              state_q      <= S_SELECT;
            end else begin
              done    <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_SELECT: begin
          if (rem_q == 8'd0) begin
            done    <= 1'b1;
            state_q <= S_DONE;
          end else if (sel_ok_d) begin
            coin_type  <= sel_type_d;
            coin_valid <= 1'b1;
            state_q    <= S_ISSUE;
          end else begin
            error     <= 1'b1;
            shortfall <= rem_q;
            state_q   <= S_FAULT;
          end
        end
        S_ISSUE: begin
          if (coin_ack) begin
            rem_q <= rem_q - coin_val(coin_type);
            stock_q[coin_type] <=
              stock_q[coin_type] - 1'b1;
            coin_valid <= 1'b0;
            state_q    <= S_SELECT;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          if (load) begin
            stock_q[load_type] <= ld_new_d;
            error     <= 1'b0;
            shortfall <= 8'd0;
            state_q   <= S_SELECT;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign inv_p = stock_q[0];
  assign inv_n = stock_q[1];
  assign inv_d = stock_q[2];
  assign inv_q = stock_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and random refunds checked against
// a greedy change-making model of the hopper inventory.
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       refund;
  logic [7:0] credit;
  logic       coin_ack;
  logic       load;
  logic [1:0] load_type;
  logic [5:0] load_count;
  logic       clear_credit;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] shortfall;
  logic [5:0] inv_p, inv_n, inv_d, inv_q;

  change_dispenser #(.INV_W(6), .INIT_INV(20)) dut (
    .clk(clk), .reset(reset), .refund(refund),
    .credit(credit), .coin_ack(coin_ack), .load(load),
    .load_type(load_type), .load_count(load_count),
    .clear_credit(clear_credit), .coin_valid(coin_valid),
    .coin_type(coin_type), .busy(busy), .done(done),
    .error(error), .shortfall(shortfall),
    .inv_p(inv_p), .inv_n(inv_n), .inv_d(inv_d),
    .inv_q(inv_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    m_inv[4];
  int    val[4] = '{1, 5, 10, 25};
  int    expq[$];
  bit    exp_fault;
  int    exp_short;
  string seq;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag,
                      input string obs,
                      input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%s expected=%s",
             tag, obs, exp);
    end
  endtask

  function automatic string cname(input int t);
    case (t)
      0: return "P";
      1: return "N";
      2: return "D";
      default: return "Q";
    endcase
  endfunction

  function automatic logic [31:0] dut_inv();
    return {8'd0, inv_q, inv_d, inv_n, inv_p};
  endfunction

  function automatic logic [31:0] mdl_inv();
    return (m_inv[3] << 18) | (m_inv[2] << 12) |
           (m_inv[1] << 6) | m_inv[0];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_inv[i] = 20;
  endfunction

  // Greedy payout on a scratch copy of the stock.
  task automatic plan(input int rem);
    int inv[4];
    int r;
    inv = m_inv;
    r = rem;
    expq.delete();
    exp_fault = 0;
    exp_short = 0;
    while (r > 0) begin
      int pick;
      pick = -1;
      for (int t = 3; t >= 0; t--)
        if (pick < 0 && val[t] <= r && inv[t] > 0)
          pick = t;
      if (pick < 0) begin
        exp_fault = 1;
        exp_short = r;
        break;
      end
      expq.push_back(pick);
      inv[pick]--;
      r -= val[pick];
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic restock(input int t, input int cnt);
    load = 1'b1;
    load_type = 2'(t);
    load_count = 6'(cnt);
    step();
    load = 1'b0;
    m_inv[t] = (m_inv[t] + cnt > 63) ? 63 : m_inv[t] + cnt;
  endtask

  task automatic refund_req(input int cr);
    credit = 8'(cr);
    refund = 1'b1;
    step();
    refund = 1'b0;
    plan(cr);
  endtask

  task automatic serve(input int dly, input int exp_cc);
    int ncc, ndone, waitc, idx, last, acc_t, cur;
    bit fin, acc;
    ncc = 0; ndone = 0; waitc = 0; idx = 0;
    last = -1; acc_t = 0; cur = 0; fin = 0; acc = 0;
    seq = "";
    coin_ack = (dly == 0);
    while (!fin && idx < 4000) begin
      if (acc) begin
        m_inv[acc_t]--;
        acc = 0;
      end
      chk("inventory", dut_inv(), mdl_inv());
      chk("busy", 32'(busy), 1);
      if (clear_credit) ncc++;
      if (done) begin
        ndone++;
        fin = 1;
        if (last >= 0) chk("ack_to_done", idx - last, 2);
      end else if (error) begin
        fin = 1;
      end else if (coin_valid) begin
        if (waitc == 0) begin
          chk("coin_type", 32'(coin_type),
              expq.size() > 0 ? expq[0] : 4);
          cur = coin_type;
          seq = {seq, cname(coin_type)};
        end else begin
          chk("coin_hold", 32'(coin_type), cur);
        end
        if (waitc >= dly) begin
          coin_ack = 1'b1;
          acc = 1;
          acc_t = expq.size() > 0 ? expq.pop_front() : cur;
          last = idx;
          waitc = 0;
        end else begin
          coin_ack = 1'b0;
          waitc++;
        end
      end else begin
        if (waitc > 0) chk("valid_hold", 32'(coin_valid), 1);
        waitc = 0;
        coin_ack = (dly == 0);
      end
      idx++;
      if (!fin) step();
    end
    coin_ack = 1'b0;
    chk("finished", 32'(fin), 1);
    chk("done_count", ndone, exp_fault ? 0 : 1);
    chk("clear_credit_count", ncc, exp_cc);
    chk("error", 32'(error), 32'(exp_fault));
    chk("shortfall", 32'(shortfall),
        exp_fault ? exp_short : 0);
    chk("coins_left", expq.size(), 0);
    if (done) begin
      step();
      chk("done_pulse", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
    end
  endtask

  task automatic pay(input int cr, input int dly);
    refund_req(cr);
    serve(dly, cr != 0 ? 1 : 0);
  endtask

  initial begin
    string pp;
    int    n;
    reset = 1'b0; refund = 1'b0; credit = 8'd0;
    coin_ack = 1'b0; load = 1'b0; load_type = 2'd0;
    load_count = 6'd0;
    model_reset();
    step(); step();
    reset = 1'b1;
    chk("reset_outputs",
        {19'd0, clear_credit, coin_valid, coin_type,
         busy, done, error, shortfall}, 0);
    chk("reset_inv", dut_inv(), mdl_inv());

    // 65 cents, ack held high
    pay(65, 0);
    chks("seq_65", seq, "QQDN");
    chk("inv_q_65", 32'(inv_q), 18);
    chk("inv_d_65", 32'(inv_d), 19);
    chk("inv_n_65", 32'(inv_n), 19);
    chk("inv_p_65", 32'(inv_p), 20);

    // zero credit
    pay(0, 0);
    chks("seq_zero", seq, "");

    // saturation
    do_reset();
    restock(3, 60);
    chk("sat_q", 32'(inv_q), 63);

    // load during ISSUE is ignored
    refund_req(25);
    coin_ack = 1'b0;
    n = 0;
    while (!coin_valid && n < 10) begin step(); n++; end
    chk("issue_reached", 32'(coin_valid), 1);
    load = 1'b1; load_type = 2'd0; load_count = 6'd10;
    step();
    load = 1'b0;
    chk("issue_load_ignored", dut_inv(), mdl_inv());
    serve(0, 0);
    chks("seq_issue_load", seq, "Q");

    // no dimes left
    do_reset();
    for (int i = 0; i < 20; i++) pay(10, 0);
    chk("dimes_gone", 32'(inv_d), 0);
    pay(41, 0);
    chks("seq_41", seq, "QNNNP");

    // fault with shortfall, then restock and resume
    do_reset();
    pay(250, 0);
    pay(250, 0);
    for (int i = 0; i < 17; i++) pay(1, 0);
    for (int i = 0; i < 20; i++) pay(5, 0);
    pay(190, 0);
    chk("setup_inv", dut_inv(), (1 << 12) | 3);
    pay(30, 0);
    chks("seq_30", seq, "DPPP");
    chk("fault_error", 32'(error), 1);
    chk("fault_short", 32'(shortfall), 17);
    restock(0, 20);
    chk("fault_cleared", 32'(error), 0);
    plan(17);
    serve(0, 0);
    pp = "";
    for (int i = 0; i < 17; i++) pp = {pp, "P"};
    chks("seq_resume", seq, pp);

    // slow hopper
    do_reset();
    pay(7, 5);
    chks("seq_7_slow", seq, "NPP");

    // reset in the middle of a payout
    refund_req(80);
    coin_ack = 1'b0;
    n = 0;
    while (!coin_valid && n < 10) begin step(); n++; end
    chk("mid_issue", 32'(coin_valid), 1);
    do_reset();
    chk("midreset_outputs",
        {19'd0, clear_credit, coin_valid, coin_type,
         busy, done, error, shortfall}, 0);
    chk("midreset_inv", dut_inv(), mdl_inv());
    pay(10, 0);
    chks("seq_after_reset", seq, "D");

    // random refunds, restocks and hopper delays
    for (int it = 0; it < 30; it++) begin
      int cr, dly, rounds;
      if ($urandom_range(0, 2) == 0)
        restock($urandom_range(0, 3), $urandom_range(0, 63));
      cr = $urandom_range(0, 255);
      dly = $urandom_range(0, 3);
      pay(cr, dly);
      rounds = 0;
      while (error && rounds < 8) begin
        int sh;
        sh = exp_short;
        restock(0, 63);
        plan(sh);
        serve(dly, 0);
        rounds++;
      end
      if (error) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
